// File: rtl/lab_pkg.sv
// Shared lab datapath constants: default counter width, direction encoding
// and the per-cycle operation select used by the counter.
package lab_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_STEP = 2'd1,
    OP_LOAD = 2'd2
  } op_e;

  // load always wins over en; en alone steps; otherwise hold
  function automatic op_e select_op(input logic load, input logic en);
    if (load) begin
      return OP_LOAD;
    end else if (en) begin
      return OP_STEP;
    end
    return OP_HOLD;
  endfunction

endpackage

// File: rtl/updown_step_counter_inc_dec_chain.sv
// Combinational WIDTH-bit ripple chain of half-adder / half-subtractor cells.
// up selects increment or decrement by one; co is carry-out or borrow-out.
module inc_dec_chain
  import lab_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic             up,
  output logic [WIDTH-1:0] y,
  output logic             co
);

  logic [WIDTH:0] c;

  assign c[0] = 1'b1;

  // Each cell propagates the +1/-1: a 1 bit absorbs a decrement borrow,
  // a 0 bit absorbs an increment carry.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      assign y[gi]   = a[gi] ^ c[gi];
      assign c[gi+1] = (up == DIR_UP) ? (a[gi] & c[gi]) : (~a[gi] & c[gi]);
    end
  endgenerate

  assign co = c[WIDTH];

endmodule

// File: rtl/updown_step_counter.sv
// Registered up/down counter with load, enable and a one-cycle carry/borrow pulse.
// Define UPDOWN_STEP_COUNTER_SAT_EN to saturate at the ends instead of wrapping.
module updown_step_counter
  import lab_pkg::*;
#(
  parameter int             WIDTH   = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic             carry,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_reg;
  logic [WIDTH-1:0] cnt_next;
  logic             carry_reg;
  logic             carry_next;
  logic [WIDTH-1:0] step_val;
  logic             step_co;
  op_e              op;

  inc_dec_chain #(
    .WIDTH(WIDTH)
  ) u_chain (
    .a (cnt_reg),
    .up(up),
    .y (step_val),
    .co(step_co)
  );

  assign op = select_op(load, en);

  always_comb begin
    cnt_next   = cnt_reg;
    carry_next = 1'b0;
    case (op)
      OP_LOAD: begin
        cnt_next = load_val;
      end
      OP_STEP: begin
`ifdef UPDOWN_STEP_COUNTER_SAT_EN
        // Chain carry-out marks an attempted overflow/underflow: pin the value.
        cnt_next   = step_co ? cnt_reg : step_val;
        carry_next = step_co;
`else
        cnt_next   = step_val;
        carry_next = step_co;
`endif
      end
      default: begin
        cnt_next = cnt_reg;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= RST_VAL;
      carry_reg <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      carry_reg <= carry_next;
    end
  end

  assign cnt   = cnt_reg;
  assign carry = carry_reg;
  assign zero  = (cnt_reg == '0);

endmodule

// File: tb/tb_updown_step_counter.sv
// Directed vector bench for updown_step_counter (WIDTH=4, RST_VAL=0),
// covering both the wrap and the saturating build.
module tb_updown_step_counter;

`ifdef UPDOWN_STEP_COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic [3:0] cnt;
  logic       carry;
  logic       zero;

  int n_checks = 0;
  int n_fail   = 0;

  updown_step_counter #(
    .WIDTH  (4),
    .RST_VAL(4'd0)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .up      (up),
    .load    (load),
    .load_val(load_val),
    .cnt     (cnt),
    .carry   (carry),
    .zero    (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       load;
    logic       en;
    logic       up;
    logic [3:0] load_val;
    logic [3:0] exp_cnt;
    logic       exp_carry;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string name, logic ld, logic e, logic u,
                              logic [3:0] v, logic [3:0] ec, logic ecy);
    vec_t t;
    t.name = name; t.load = ld; t.en = e; t.up = u;
    t.load_val = v; t.exp_cnt = ec; t.exp_carry = ecy;
    vecs.push_back(t);
  endfunction

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(string name, logic [3:0] ec, logic ecy);
    check({name, ".cnt"}, int'(cnt), int'(ec));
    check({name, ".carry"}, int'(carry), int'(ecy));
    check({name, ".zero"}, int'(zero), int'(ec == 4'd0));
    $display("%-14s load=%0d en=%0d up=%0d val=%0d -> cnt=%0d carry=%0d zero=%0d",
             name, load, en, up, load_val, cnt, carry, zero);
  endtask

  task automatic drive_step(logic ld, logic e, logic u, logic [3:0] v);
    @(negedge clk);
    load = ld; en = e; up = u; load_val = v;
    @(posedge clk);
    #1;
  endtask

  int up_carries;
  int dn_carries;
  logic [3:0] exp_val;
  logic       exp_cy;

  initial begin
    // Reset state, asserted before any edge
    #2;
    check_all("reset", 4'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Up wrap
    add("ld14",    1, 0, 1, 4'd14, 4'd14, 0);
    add("up_a",    0, 1, 1, 4'd0,  4'd15, 0);
    add("up_b",    0, 1, 1, 4'd0,  SAT ? 4'd15 : 4'd0, 1);
    add("up_c",    0, 1, 1, 4'd0,  SAT ? 4'd15 : 4'd1, SAT);
    // Down borrow
    add("ld1",     1, 0, 0, 4'd1,  4'd1,  0);
    add("dn_a",    0, 1, 0, 4'd0,  4'd0,  0);
    add("dn_b",    0, 1, 0, 4'd0,  SAT ? 4'd0 : 4'd15, 1);
    add("dn_c",    0, 1, 0, 4'd0,  SAT ? 4'd0 : 4'd14, SAT);
    // Priority: load over en
    add("ld15",    1, 0, 0, 4'd15, 4'd15, 0);
    add("ld_pri",  1, 1, 1, 4'd7,  4'd7,  0);
    add("hold_a",  0, 0, 1, 4'd3,  4'd7,  0);
    add("hold_b",  0, 0, 0, 4'd3,  4'd7,  0);
    add("hold_c",  0, 0, 1, 4'd3,  4'd7,  0);
    add("hold_d",  0, 0, 0, 4'd3,  4'd7,  0);
    // Same-cycle direction change
    add("dir_up",  0, 1, 1, 4'd0,  4'd8,  0);
    add("dir_dn",  0, 1, 0, 4'd0,  4'd7,  0);
    // Back-to-back events at the boundary
    add("ld15b",   1, 0, 0, 4'd15, 4'd15, 0);
    add("b2b_up",  0, 1, 1, 4'd0,  SAT ? 4'd15 : 4'd0, 1);
    add("b2b_dn",  0, 1, 0, 4'd0,  SAT ? 4'd14 : 4'd15, !SAT);
    add("after",   0, 0, 0, 4'd0,  SAT ? 4'd14 : 4'd15, 0);
    // Load of 0 then underflow attempt
    add("ld0",     1, 0, 1, 4'd0,  4'd0,  0);
    add("dn0",     0, 1, 0, 4'd0,  SAT ? 4'd0 : 4'd15, 1);
    add("ld_clr",  1, 1, 0, 4'd9,  4'd9,  0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive_step(vecs[i].load, vecs[i].en, vecs[i].up, vecs[i].load_val);
      check_all(vecs[i].name, vecs[i].exp_cnt, vecs[i].exp_carry);
    end

    // Reset between edges with a step pending: takes effect immediately
    @(negedge clk);
    load = 1'b0; en = 1'b1; up = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 4'd0, 1'b0);
    @(posedge clk);
    #1;
    check_all("rst_held", 4'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("first_step", 4'd1, 1'b0);

    // Full sweep from reset: 16 up then 16 down
    @(negedge clk);
    rst_n = 1'b0;
    en = 1'b0;
    #1;
    rst_n = 1'b1;
    up_carries = 0;
    dn_carries = 0;
    exp_val = 4'd0;
    for (int i = 1; i <= 16; i++) begin
      exp_cy  = (exp_val == 4'd15);
      exp_val = (SAT && exp_cy) ? exp_val : exp_val + 4'd1;
      drive_step(1'b0, 1'b1, 1'b1, 4'd0);
      check_all($sformatf("sweep_up%0d", i), exp_val, exp_cy);
      if (carry) up_carries++;
    end
    for (int i = 1; i <= 16; i++) begin
      exp_cy  = (exp_val == 4'd0);
      exp_val = (SAT && exp_cy) ? exp_val : exp_val - 4'd1;
      drive_step(1'b0, 1'b1, 1'b0, 4'd0);
      check_all($sformatf("sweep_dn%0d", i), exp_val, exp_cy);
      if (carry) dn_carries++;
    end
    check("sweep_up_carries", up_carries, 1);
    check("sweep_dn_carries", dn_carries, 1);
    check("sweep_end_cnt", int'(cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
